store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
- CPU-side write path between the execute stage and the memory bus; counterpart to the load unit on the read side.
- Accepts one 32-bit store with byte enables at any byte address.
- A store that crosses a word boundary is split into two aligned word writes: low word first, then high word.
- Data and byte enables are shifted into lane position, and a done pulse is raised once the last word write has been accepted.

Parameters:
- None. Address and data widths are fixed at 32 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- write_ready  output  1  high when idle and able to accept a store
- write_req  input  1  store request, sampled only while write_ready=1
- write_addr  input  32  byte address of the store (any alignment)
- write_data  input  32  store data, right-aligned (byte 0 = write_data[7:0])
- write_byte_enable  input  4  enables for the right-aligned bytes (4'h1 byte, 4'h3 half, 4'hf word)
- write_done  output  1  one-cycle pulse: the whole store has been accepted by memory
- mem_ready  input  1  memory accepts a request this cycle
- mem_addr  output  32  word-aligned address; [1:0] always 2'h0
- mem_write_data  output  32  lane-positioned write data
- mem_byte_enable  output  4  lane byte enables
- mem_write_req  output  1  write request; held until accepted

Behaviour:
- All outputs are registered.
- Reset values: write_done=0, mem_write_req=0, mem_addr=0, mem_write_data=0, mem_byte_enable=0, state=IDLE (so write_ready=1).
- Reset mid-operation: any pending request is dropped at the next edge. A low word already accepted is not rolled back.
- write_ready is combinational: state==IDLE.
- States: IDLE, STORE_LOW, STORE_HIGH.
- Capture in IDLE with write_req=1:
  - lo = write_addr[1:0]
  - be8 = {4'h0, write_byte_enable} << lo
  - d64 = {32'h0, write_data} << {lo, 3'h0}
  - base = {write_addr[31:2], 2'h0}
  - hi_addr = {write_addr[31:2] + 30'h1, 2'h0}; wraps 0xfffffffc -> 0x00000000
- IDLE transitions:
  - be8==0: no memory request; write_done=1 next cycle; stay IDLE.
  - be8[3:0]!=0: drive mem_addr=base, mem_write_data=d64[31:0], mem_byte_enable=be8[3:0], mem_write_req=1; go to STORE_LOW.
  - be8[3:0]==0 and be8[7:4]!=0: not reachable with legal enables; must still work. Drive hi_addr, d64[63:32], be8[7:4], mem_write_req=1; go to STORE_HIGH.
- Acceptance: a request is accepted in any cycle where mem_write_req=1 and mem_ready=1.
- STORE_LOW on acceptance:
  - be8[7:4]==0: mem_write_req=0, write_done=1, go to IDLE.
  - otherwise: mem_addr=hi_addr, mem_write_data=d64[63:32], mem_byte_enable=be8[7:4]; mem_write_req stays 1; go to STORE_HIGH.
- STORE_HIGH on acceptance: mem_write_req=0, write_done=1, go to IDLE.
- No acceptance: mem_addr, mem_write_data, mem_byte_enable and mem_write_req are held stable.
- Latency with mem_ready tied high:
  - Aligned store: write_req at cycle N; mem_write_req high in N+1; write_done in N+2.
  - Split store: write_done in N+3.
- write_done and write_ready=1 appear in the same cycle; the next store can be captured in that cycle.
- write_req while not IDLE is ignored; the source must hold it until write_ready is high.
- write_done is high for exactly one cycle per accepted store, including stores with zero byte enables.

Test Plan:
- Aligned word, mem_ready=1:
  - stimulus: addr 0x00001000, data 0xdeadbeef, be 4'hf
  - response: one request with mem_addr 0x1000, data 0xdeadbeef, be 4'hf; write_done 2 cycles after write_req.
- Byte at offset 3:
  - stimulus: addr 0x2003, data 0x000000a5, be 4'h1
  - response: one request with mem_addr 0x2000, data 0xa5000000, be 4'h8.
- Misaligned word:
  - stimulus: addr 0x3002, data 0x11223344, be 4'hf
  - response: first 0x3000 / 0x33440000 / be 4'hc, then 0x3004 / 0x00001122 / be 4'h3; write_done 3 cycles after write_req.
- Back-pressure on a split halfword:
  - stimulus: addr 0x4003, data 0x0000beef, be 4'h3; mem_ready low 3 cycles on each word
  - response: outputs stable while stalled; second request 0x4004 / be 4'h1 / data 0x000000be; exactly one write_done.
- Address wrap and zero enables:
  - stimulus 1: addr 0xfffffffe, be 4'hf
  - response 1: second request at mem_addr 0x00000000, be 4'h3.
  - stimulus 2: be 4'h0
  - response 2: no mem_write_req; write_done next cycle.
- Reset mid-store:
  - stimulus: reset asserted while in STORE_HIGH with mem_ready low
  - response: mem_write_req=0, write_done=0, write_ready=1 after the edge; a new store at 0x5000 completes normally.

Source files
------------

// File: rtl/store_unit.sv
// Store unit: turns one byte-enabled 32-bit store at any byte address into one
// or two word-aligned memory writes, then pulses write_done.
module store_unit (
  input  logic        clk,
  input  logic        reset,
  output logic        write_ready,
  input  logic        write_req,
  input  logic [31:0] write_addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_byte_enable,
  output logic        write_done,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_enable,
  output logic        mem_write_req
);

  typedef enum logic [1:0] {IDLE, STORE_LOW, STORE_HIGH} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic [31:0] hi_addr_q, hi_addr_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_be_q, hi_be_d;

  logic [1:0]  lo;
  logic [7:0]  be8;
  logic [63:0] d64;
  logic [31:0] base;
  logic [31:0] hi_addr;
  logic        accepted;

  always_comb begin
    lo      = write_addr[1:0];
    be8     = {4'h0, write_byte_enable} << lo;
    d64     = {32'h0, write_data} << {lo, 3'h0};
    base    = {write_addr[31:2], 2'h0};
    hi_addr = {write_addr[31:2] + 30'h1, 2'h0};
  end

  assign accepted = req_q && mem_ready;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    req_d     = req_q;
    done_d    = 1'b0;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
    unique case (state_q)
      IDLE: begin
        if (write_req) begin
          hi_addr_d = hi_addr;
          hi_data_d = d64[63:32];
          hi_be_d   = be8[7:4];
          if (be8 == 8'h00) begin
            done_d = 1'b1;
          end else if (be8[3:0] != 4'h0) begin
            addr_d  = base;
            data_d  = d64[31:0];
            be_d    = be8[3:0];
            req_d   = 1'b1;
            state_d = STORE_LOW;
          end else begin
            // Only the upper word has lanes: skip straight to the high write.
            addr_d  = hi_addr;
            data_d  = d64[63:32];
            be_d    = be8[7:4];
            req_d   = 1'b1;
            state_d = STORE_HIGH;
          end
        end
      end
      STORE_LOW: begin
        if (accepted) begin
          if (hi_be_q == 4'h0) begin
            req_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = hi_addr_q;
            data_d  = hi_data_q;
            be_d    = hi_be_q;
            state_d = STORE_HIGH;
          end
        end
      end
      STORE_HIGH: begin
        if (accepted) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      be_q      <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
      hi_addr_q <= '0;
      hi_data_q <= '0;
      hi_be_q   <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      req_q     <= req_d;
      done_q    <= done_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
    end
  end

  assign write_ready     = (state_q == IDLE);
  assign write_done      = done_q;
  assign mem_addr        = addr_q;
  assign mem_write_data  = data_q;
  assign mem_byte_enable = be_q;
  assign mem_write_req   = req_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: expected memory writes are queued when a
// store is driven and compared whenever the DUT presents a request.
module tb_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_ready;
  logic        write_req;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic [3:0]  write_byte_enable;
  logic        write_done;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_req;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_count = 0;
  int   exp_done = 0;
  bit   monitor_on = 1'b0;

  always #5 clk = ~clk;

  store_unit dut (
    .clk(clk),
    .reset(reset),
    .write_ready(write_ready),
    .write_req(write_req),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_byte_enable(write_byte_enable),
    .write_done(write_done),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_write_data(mem_write_data),
    .mem_byte_enable(mem_byte_enable),
    .mem_write_req(mem_write_req)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r.addr = a;
    r.data = d;
    r.be   = be;
    exp_q.push_back(r);
  endtask

  // Every presented request must match the queue head, stalled or not;
  // it is retired when the upcoming edge accepts it.
  always @(negedge clk) begin
    if (monitor_on && !reset) begin
      if (write_done) done_count++;
      if (mem_write_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_req", 32'd1, 32'd0);
        end else begin
          check("mem_addr", mem_addr, exp_q[0].addr);
          check("mem_data", mem_write_data, exp_q[0].data);
          check("mem_be", {28'h0, mem_byte_enable}, {28'h0, exp_q[0].be});
          if (mem_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // exp_lat counts edges from presenting write_req to write_done visible; 0 skips it.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                          input int exp_lat);
    int n;
    n = 0;
    while (!write_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before", {31'h0, write_ready}, 32'd1);
    write_addr = a;
    write_data = d;
    write_byte_enable = be;
    write_req = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      write_req = 1'b0;
      n++;
    end while (!write_done && n < 100);
    check("done_seen", {31'h0, write_done}, 32'd1);
    check("ready_at_done", {31'h0, write_ready}, 32'd1);
    if (exp_lat > 0) check("latency", n, exp_lat);
    exp_done++;
  endtask

  task automatic stall_driver();
    int n;
    n = 0;
    mem_ready = 1'b0;
    do begin
      @(posedge clk); #1; n++;
    end while (!mem_write_req && n < 100);
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
    @(posedge clk);
    #1 mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 mem_ready = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    write_req = 1'b0;
    write_addr = '0;
    write_data = '0;
    write_byte_enable = '0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, write_ready}, 32'd1);
    check("rst_done", {31'h0, write_done}, 32'd0);
    check("rst_req", {31'h0, mem_write_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", mem_write_data, 32'h0);
    check("rst_be", {28'h0, mem_byte_enable}, 32'h0);
    reset = 1'b0;
    monitor_on = 1'b1;

    push_req(32'h0000_1000, 32'hdead_beef, 4'hf);
    do_store(32'h0000_1000, 32'hdead_beef, 4'hf, 2);

    push_req(32'h0000_2000, 32'ha500_0000, 4'h8);
    do_store(32'h0000_2003, 32'h0000_00a5, 4'h1, 2);

    push_req(32'h0000_3000, 32'h3344_0000, 4'hc);
    push_req(32'h0000_3004, 32'h0000_1122, 4'h3);
    do_store(32'h0000_3002, 32'h1122_3344, 4'hf, 3);

    push_req(32'h0000_4000, 32'hef00_0000, 4'h8);
    push_req(32'h0000_4004, 32'h0000_00be, 4'h1);
    fork
      do_store(32'h0000_4003, 32'h0000_beef, 4'h3, 0);
      stall_driver();
    join

    push_req(32'hffff_fffc, 32'hf00d_0000, 4'hc);
    push_req(32'h0000_0000, 32'h0000_cafe, 4'h3);
    do_store(32'hffff_fffe, 32'hcafe_f00d, 4'hf, 3);

    do_store(32'h0000_7001, 32'h1234_5678, 4'h0, 1);

    push_req(32'h0000_8000, 32'h0000_5566, 4'h3);
    do_store(32'h0000_8000, 32'h0000_5566, 4'h3, 2);

    // Reset mid-store: the low word goes through, the high word is stuck and dropped.
    push_req(32'h0000_6000, 32'h7788_0000, 4'hc);
    push_req(32'h0000_6004, 32'h0000_99aa, 4'h3);
    write_addr = 32'h0000_6002;
    write_data = 32'h99aa_7788;
    write_byte_enable = 4'hf;
    write_req = 1'b1;
    @(posedge clk); #1;
    write_req = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stuck_req", {31'h0, mem_write_req}, 32'd1);
    check("stuck_ready", {31'h0, write_ready}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_req", {31'h0, mem_write_req}, 32'd0);
    check("mid_rst_done", {31'h0, write_done}, 32'd0);
    check("mid_rst_ready", {31'h0, write_ready}, 32'd1);
    check("dropped_pending", exp_q.size(), 32'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    mem_ready = 1'b1;

    push_req(32'h0000_5000, 32'h0bad_f00d, 4'hf);
    do_store(32'h0000_5000, 32'h0bad_f00d, 4'hf, 2);

    n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", done_count, exp_done);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
